jbi_snpq_req_tx: RTL and testbench

JBI-side transmitter for the JBI-to-sctag request interface. It accepts one DMA request per handshake (header fields, 40-bit address, 64-bit data) and serializes it as four back-to-back 32-bit words on `jbi_sctag_req`. The sctag snoop queue captures these words in order: header, address, data-high, data-low. Flow control is credit-based and tracks the free entries in the sctag 2-entry snoop queue; sctag returns one credit per entry dequeued.

---
 rtl/jbi_snpq_req_tx.sv | 126 ++++++++++++
 tb/tb_jbi_snpq_req_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jbi_snpq_req_tx.sv
// JBI-to-sctag request transmitter: captures one DMA request per handshake and
// serializes it as header/address/data-high/data-low words under snoop-queue credit flow control.
//
// state | meaning
// IDLE  | bus idle (0), waiting for an accepted request
// HDR   | header word on bus, jbi_sctag_req_vld high
// ADDR  | addr[31:0] on bus
// D1    | data[63:32] on bus
// D2    | data[31:0] on bus; next request may be accepted here with no bubble
module jbi_snpq_req_tx #(
  parameter int CREDITS = 2,
  parameter int CW      = 2
) (
  input  logic          rclk,
  input  logic          arst_l,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic          req_wr64,
  input  logic          req_wr8,
  input  logic          req_rd,
  input  logic          req_poison,
  input  logic [11:0]   req_ctag,
  input  logic [2:0]    req_sz,
  input  logic [39:0]   req_addr,
  input  logic [63:0]   req_data,
  output logic [31:0]   jbi_sctag_req,
  output logic          jbi_sctag_req_vld,
  input  logic          sctag_jbi_iq_dequeue,
  output logic [CW-1:0] credit_cnt,
  output logic          credit_err
);

  typedef enum logic [2:0] {IDLE, HDR, ADDR, D1, D2} state_e;

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  state_e         state_q, state_d;
  logic [31:0]    addr_lo_q, addr_lo_d;
  logic [63:0]    data_q, data_d;
  logic [31:0]    bus_q, bus_d;
  logic           vld_q, vld_d;
  logic [CW-1:0]  credit_cnt_q, credit_cnt_d;
  logic           credit_err_q, credit_err_d;
  logic           accept;
  logic [31:0]    hdr_word;

  assign req_rdy = ((state_q == IDLE) || (state_q == D2)) && (credit_cnt_q != '0);
  assign accept  = req_vld && req_rdy;

  assign hdr_word = {4'b0000, req_poison, req_wr64, req_wr8, req_rd,
                     req_ctag, 1'b0, req_sz, req_addr[39:32]};

  // The bus register is loaded with the word for the state being entered.
  always_comb begin
    state_d   = state_q;
    addr_lo_d = addr_lo_q;
    data_d    = data_q;
    bus_d     = '0;
    vld_d     = 1'b0;
    if (accept) begin
      addr_lo_d = req_addr[31:0];
      data_d    = req_rd ? 64'd0 : req_data;
    end
    case (state_q)
      IDLE, D2: begin
        if (accept) begin
          state_d = HDR;
          bus_d   = hdr_word;
          vld_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        state_d = ADDR;
        bus_d   = addr_lo_q;
      end
      ADDR: begin
        state_d = D1;
        bus_d   = data_q[63:32];
      end
      D1: begin
        state_d = D2;
        bus_d   = data_q[31:0];
      end
      default: state_d = IDLE;
    endcase
  end

  // A dequeue with every entry already free is a protocol error; the count saturates.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    credit_err_d = sctag_jbi_iq_dequeue && (credit_cnt_q == CRED_MAX);
    if (accept && !sctag_jbi_iq_dequeue) begin
      credit_cnt_d = credit_cnt_q - CW'(1);
    end else if (!accept && sctag_jbi_iq_dequeue && (credit_cnt_q != CRED_MAX)) begin
      credit_cnt_d = credit_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q      <= IDLE;
      addr_lo_q    <= '0;
      data_q       <= '0;
      bus_q        <= '0;
      vld_q        <= 1'b0;
      credit_cnt_q <= CRED_MAX;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_lo_q    <= addr_lo_d;
      data_q       <= data_d;
      bus_q        <= bus_d;
      vld_q        <= vld_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign jbi_sctag_req     = bus_q;
  assign jbi_sctag_req_vld = vld_q;
  assign credit_cnt        = credit_cnt_q;
  assign credit_err        = credit_err_q;

endmodule

// File: tb/tb_jbi_snpq_req_tx.sv
// Self-checking bench for jbi_snpq_req_tx: directed scenarios plus a randomized run
// checked against a word-queue/credit-count reference model.
module tb_jbi_snpq_req_tx;

  localparam int CREDITS = 2;
  localparam int CW      = 2;

  logic          rclk = 1'b0;
  logic          arst_l;
  logic          req_vld;
  logic          req_rdy;
  logic          req_wr64, req_wr8, req_rd, req_poison;
  logic [11:0]   req_ctag;
  logic [2:0]    req_sz;
  logic [39:0]   req_addr;
  logic [63:0]   req_data;
  logic [31:0]   jbi_sctag_req;
  logic          jbi_sctag_req_vld;
  logic          sctag_jbi_iq_dequeue;
  logic [CW-1:0] credit_cnt;
  logic          credit_err;

  int n_pass  = 0;
  int n_total = 0;

  jbi_snpq_req_tx #(.CREDITS(CREDITS), .CW(CW)) dut (
    .rclk                 (rclk),
    .arst_l               (arst_l),
    .req_vld              (req_vld),
    .req_rdy              (req_rdy),
    .req_wr64             (req_wr64),
    .req_wr8              (req_wr8),
    .req_rd               (req_rd),
    .req_poison           (req_poison),
    .req_ctag             (req_ctag),
    .req_sz               (req_sz),
    .req_addr             (req_addr),
    .req_data             (req_data),
    .jbi_sctag_req        (jbi_sctag_req),
    .jbi_sctag_req_vld    (jbi_sctag_req_vld),
    .sctag_jbi_iq_dequeue (sctag_jbi_iq_dequeue),
    .credit_cnt           (credit_cnt),
    .credit_err           (credit_err)
  );

  always #5 rclk = ~rclk;

  // Reference model: words still to appear on the bus ({vld, word}) and free credits.
  logic [32:0] m_words[$];
  int          m_cred;
  logic [31:0] m_bus;
  logic        m_vld;
  logic        m_err;
  logic        m_acc;

  function automatic logic [31:0] model_hdr();
    return {4'h0, req_poison, req_wr64, req_wr8, req_rd, req_ctag, 1'b0, req_sz, req_addr[39:32]};
  endfunction

  function automatic logic model_rdy();
    return (m_words.size() == 0) && (m_cred != 0);
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_cred = CREDITS;
    m_bus  = '0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
    m_acc  = 1'b0;
  endtask

  // Advance one clock; returns at posedge+1 with the model describing the new cycle.
  task automatic step();
    logic        acc, deq;
    logic [32:0] w;
    logic [63:0] d;
    acc = req_vld && model_rdy();
    deq = sctag_jbi_iq_dequeue;
    @(posedge rclk);
    m_err = deq && (m_cred == CREDITS);
    if (acc) begin
      d = req_rd ? 64'd0 : req_data;
      m_words.push_back({1'b1, model_hdr()});
      m_words.push_back({1'b0, req_addr[31:0]});
      m_words.push_back({1'b0, d[63:32]});
      m_words.push_back({1'b0, d[31:0]});
    end
    if (acc && !deq) m_cred--;
    else if (!acc && deq && m_cred < CREDITS) m_cred++;
    if (m_words.size() > 0) begin
      w     = m_words.pop_front();
      m_vld = w[32];
      m_bus = w[31:0];
    end else begin
      m_vld = 1'b0;
      m_bus = '0;
    end
    m_acc = acc;
    #1;
  endtask

  task automatic rand_req();
    req_wr64   = 1'($urandom);
    req_wr8    = 1'($urandom);
    req_rd     = 1'($urandom);
    req_poison = 1'($urandom);
    req_ctag   = 12'($urandom);
    req_sz     = 3'($urandom);
    req_addr   = {8'($urandom), $urandom};
    req_data   = {$urandom, $urandom};
  endtask

  task automatic apply_reset();
    arst_l               = 1'b0;
    req_vld              = 1'b0;
    sctag_jbi_iq_dequeue = 1'b0;
    rand_req();
    model_reset();
    repeat (2) @(posedge rclk);
    #1 arst_l = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++; if (jbi_sctag_req !== 32'h0) $display("FAIL reset_bus: got %h want 0", jbi_sctag_req); else n_pass++;
    n_total++; if (jbi_sctag_req_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", jbi_sctag_req_vld); else n_pass++;
    n_total++; if (credit_cnt !== CW'(CREDITS)) $display("FAIL reset_credit: got %0d want %0d", credit_cnt, CREDITS); else n_pass++;
    n_total++; if (credit_err !== 1'b0) $display("FAIL reset_err: got %b want 0", credit_err); else n_pass++;
    n_total++; if (req_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", req_rdy); else n_pass++;
  endtask

  task automatic test_single_write();
    logic [31:0] exp_w[5];
    exp_w = '{32'h045A36AB, 32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0};
    apply_reset();
    req_wr64 = 1'b1; req_wr8 = 1'b0; req_rd = 1'b0; req_poison = 1'b0;
    req_ctag = 12'h5A3; req_sz = 3'b110;
    req_addr = 40'hAB_1234_5678; req_data = 64'hDEADBEEF_CAFEF00D;
    req_vld = 1'b1;
    step();
    req_vld = 1'b0;
    rand_req();
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (jbi_sctag_req !== exp_w[i]) $display("FAIL write_word%0d: got %h want %h", i, jbi_sctag_req, exp_w[i]);
      else n_pass++;
      n_total++;
      if (jbi_sctag_req_vld !== (i == 0)) $display("FAIL write_vld%0d: got %b want %b", i, jbi_sctag_req_vld, (i == 0));
      else n_pass++;
      if (i == 0) begin
        n_total++; if (credit_cnt !== CW'(1)) $display("FAIL write_credit: got %0d want 1", credit_cnt); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_read();
    logic [31:0] exp_hdr;
    apply_reset();
    rand_req();
    req_rd = 1'b1; req_poison = 1'b1; req_data = 64'hFFFF_0000_1234_5678;
    exp_hdr = model_hdr();
    req_vld = 1'b1;
    step();
    req_vld = 1'b0;
    n_total++; if (jbi_sctag_req[27] !== 1'b1 || jbi_sctag_req[24] !== 1'b1)
      $display("FAIL read_hdr_bits: got %h want bits 27,24 set", jbi_sctag_req); else n_pass++;
    n_total++; if (jbi_sctag_req !== exp_hdr) $display("FAIL read_hdr: got %h want %h", jbi_sctag_req, exp_hdr); else n_pass++;
    step();
    step();
    n_total++; if (jbi_sctag_req !== 32'h0) $display("FAIL read_data_hi: got %h want 0", jbi_sctag_req); else n_pass++;
    step();
    n_total++; if (jbi_sctag_req !== 32'h0) $display("FAIL read_data_lo: got %h want 0", jbi_sctag_req); else n_pass++;
  endtask

  task automatic test_credit_exhaustion();
    int n_acc;
    int c1;
    int exp_cred;
    apply_reset();
    rand_req();
    req_vld = 1'b1;
    n_acc = 0;
    for (int c = 0; c <= 15; c++) begin
      sctag_jbi_iq_dequeue = (c == 10);
      if (c >= 5 && c <= 10) begin
        n_total++; if (req_rdy !== 1'b0) $display("FAIL exh_rdy_low c%0d: got %b want 0", c, req_rdy); else n_pass++;
      end
      if (c == 11) begin
        n_total++; if (req_rdy !== 1'b1) $display("FAIL exh_rdy_back: got %b want 1", req_rdy); else n_pass++;
      end
      step();
      c1 = c + 1;
      n_total++;
      if (jbi_sctag_req_vld !== (c1 == 1 || c1 == 5 || c1 == 12))
        $display("FAIL exh_vld c%0d: got %b want %b", c1, jbi_sctag_req_vld, (c1 == 1 || c1 == 5 || c1 == 12));
      else n_pass++;
      exp_cred = (c1 < 5) ? 1 : (c1 < 11) ? 0 : (c1 < 12) ? 1 : 0;
      n_total++;
      if (credit_cnt !== CW'(exp_cred)) $display("FAIL exh_credit c%0d: got %0d want %0d", c1, credit_cnt, exp_cred);
      else n_pass++;
      if (m_acc) begin
        n_acc++;
        if (n_acc == 3) req_vld = 1'b0;
        else rand_req();
      end
    end
    sctag_jbi_iq_dequeue = 1'b0;
  endtask

  task automatic test_back_to_back_simul();
    apply_reset();
    rand_req();
    req_vld = 1'b1;
    step();
    req_vld = 1'b0;
    repeat (3) step();
    n_total++; if (credit_cnt !== CW'(1)) $display("FAIL simul_pre_credit: got %0d want 1", credit_cnt); else n_pass++;
    n_total++; if (req_rdy !== 1'b1) $display("FAIL simul_rdy_d2: got %b want 1", req_rdy); else n_pass++;
    rand_req();
    req_vld = 1'b1;
    sctag_jbi_iq_dequeue = 1'b1;
    step();
    req_vld = 1'b0;
    sctag_jbi_iq_dequeue = 1'b0;
    n_total++; if (credit_cnt !== CW'(1)) $display("FAIL simul_credit: got %0d want 1", credit_cnt); else n_pass++;
    n_total++; if (jbi_sctag_req_vld !== 1'b1 || jbi_sctag_req !== m_bus)
      $display("FAIL simul_b2b_hdr: got %b/%h want 1/%h", jbi_sctag_req_vld, jbi_sctag_req, m_bus); else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    sctag_jbi_iq_dequeue = 1'b1;
    step();
    sctag_jbi_iq_dequeue = 1'b0;
    n_total++; if (credit_cnt !== CW'(CREDITS)) $display("FAIL ovf_credit: got %0d want %0d", credit_cnt, CREDITS); else n_pass++;
    n_total++; if (credit_err !== 1'b1) $display("FAIL ovf_err: got %b want 1", credit_err); else n_pass++;
    step();
    n_total++; if (credit_err !== 1'b0) $display("FAIL ovf_err_pulse: got %b want 0", credit_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_addr;
    apply_reset();
    rand_req();
    exp_addr = req_addr[31:0];
    req_vld = 1'b1;
    step();
    req_vld = 1'b0;
    step();
    n_total++; if (jbi_sctag_req !== exp_addr) $display("FAIL rstmid_addr: got %h want %h", jbi_sctag_req, exp_addr); else n_pass++;
    #2 arst_l = 1'b0;
    #1;
    n_total++; if (jbi_sctag_req !== 32'h0 || jbi_sctag_req_vld !== 1'b0)
      $display("FAIL rstmid_async: got %h/%b want 0/0", jbi_sctag_req, jbi_sctag_req_vld); else n_pass++;
    model_reset();
    @(posedge rclk);
    #1 arst_l = 1'b1;
    n_total++; if (credit_cnt !== CW'(CREDITS)) $display("FAIL rstmid_credit: got %0d want %0d", credit_cnt, CREDITS); else n_pass++;
    n_total++; if (req_rdy !== 1'b1) $display("FAIL rstmid_rdy: got %b want 1", req_rdy); else n_pass++;
    rand_req();
    exp_addr = req_addr[31:0];
    req_vld = 1'b1;
    step();
    req_vld = 1'b0;
    n_total++; if (jbi_sctag_req_vld !== 1'b1 || jbi_sctag_req !== m_bus)
      $display("FAIL rstmid_next_hdr: got %b/%h want 1/%h", jbi_sctag_req_vld, jbi_sctag_req, m_bus); else n_pass++;
    step();
    n_total++; if (jbi_sctag_req !== exp_addr) $display("FAIL rstmid_next_addr: got %h want %h", jbi_sctag_req, exp_addr); else n_pass++;
  endtask

  task automatic test_random();
    int n_bad;
    n_bad = 0;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      rand_req();
      req_vld = ($urandom_range(0, 2) != 0);
      sctag_jbi_iq_dequeue = ($urandom_range(0, 3) == 0);
      n_total++;
      if (req_rdy !== model_rdy()) begin
        $display("FAIL rand_rdy cyc%0d: got %b want %b", i, req_rdy, model_rdy());
      end else n_pass++;
      step();
      n_total++;
      if (jbi_sctag_req !== m_bus || jbi_sctag_req_vld !== m_vld) begin
        if (n_bad < 10) $display("FAIL rand_bus cyc%0d: got %b/%h want %b/%h", i, jbi_sctag_req_vld, jbi_sctag_req, m_vld, m_bus);
        n_bad++;
      end else n_pass++;
      n_total++;
      if (credit_cnt !== CW'(m_cred) || credit_err !== m_err) begin
        if (n_bad < 10) $display("FAIL rand_credit cyc%0d: got %0d/%b want %0d/%b", i, credit_cnt, credit_err, m_cred, m_err);
        n_bad++;
      end else n_pass++;
    end
    req_vld = 1'b0;
    sctag_jbi_iq_dequeue = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_credit_exhaustion();
    test_back_to_back_simul();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
